// File: rtl/ft600_mch_capture_pkg.sv
// Shared types and constants for the FT600 multi-channel capture controller.
package ft600_mch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_OE    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_HEADER   = 3'd4,
    ST_STREAM   = 3'd5,
    ST_LOOPBACK = 3'd6
  } state_e;

  localparam logic [3:0]  OP_LEN_LO  = 4'h1;
  localparam logic [3:0]  OP_LEN_HI  = 4'h2;
  localparam logic [3:0]  OP_DECIM   = 4'h3;
  localparam logic [3:0]  OP_LOOP    = 4'h7;
  localparam logic [3:0]  OP_CAPTURE = 4'hA;

  localparam logic [15:0] FRAME_HDR  = 16'hA55A;
  localparam int          LEN_W      = 28;

  // Zero or oversize lengths fall back to the full buffer depth.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] depth);
    return (len == '0 || len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/ft600_mch_capture_buf.sv
// Sample capture memory: single write port, registered read, write-first on
// address collision so a same-cycle store is visible to the prefetch read.
module capture_buf #(
  parameter int DEPTH = 4096,
  parameter int W     = 20,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_ft_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge i_ft_clk) begin
    if (we) mem[waddr] <= wdata;
    if (we && waddr == raddr) rdata <= wdata;
    else                      rdata <= mem[raddr];
  end

endmodule

// File: rtl/ft600_mch_capture.sv
// FT600 245-FIFO command decoder, multi-channel sample capture and streamer.
// Optional FRAME_HEADER_EN prefixes each streamed frame with two header words.
module ft600_mch_capture
  import ft600_mch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BE_W   = 2,
  parameter int NCH    = 2,
  parameter int ADC_W  = 10,
  parameter int DEPTH  = 4096,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                 i_ft_clk,
  input  logic                 rst,
  input  logic                 i_ft_rxf_n,
  input  logic                 i_ft_txe_n,
  output logic                 o_ft_oe_n,
  output logic                 o_ft_rd_n,
  output logic                 o_ft_wr_n,
  inout  wire  [BE_W-1:0]      io_ft_be,
  inout  wire  [DATA_W-1:0]    io_ft_data,
  input  logic                 i_smp_valid,
  input  logic [NCH*ADC_W-1:0] i_smp_data,
  output logic                 o_busy,
  output logic [2:0]           o_state
);

  localparam int SW  = NCH * ADC_W;
  localparam int WLW = AW + 5;

  state_e             state_q, state_d;
  logic               oe_n_q, oe_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic [15:0]        data_q, data_d, cmd_q, cmd_d;
  logic [LEN_W-1:0]   cap_len_q, cap_len_d;
  logic [7:0]         decim_q, decim_d, dcnt_q, dcnt_d;
  logic [AW:0]        wr_cnt_q, wr_cnt_d, eff_len_q, eff_len_d;
  logic [AW-1:0]      samp_q, samp_d;
  logic [3:0]         ch_q, ch_d;
  logic [WLW-1:0]     left_q, left_d;
  logic               hdr_q, hdr_d;
  logic               buf_we;
  logic [SW-1:0]      rdata;
  logic [11:0]        smp12;
  logic [AW:0]        eff_c;

  assign io_ft_data = o_ft_oe_n ? data_q : {DATA_W{1'bz}};
  assign io_ft_be   = o_ft_oe_n ? {BE_W{~o_ft_wr_n}} : {BE_W{1'bz}};
  assign o_ft_oe_n  = oe_n_q;
  assign o_ft_rd_n  = rd_n_q;
  assign o_ft_wr_n  = wr_n_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_state    = state_q;

  // Read address follows samp_d so rdata already holds samp_q's sample.
  capture_buf #(.DEPTH(DEPTH), .W(SW), .AW(AW)) u_buf (
    .i_ft_clk (i_ft_clk),
    .we       (buf_we),
    .waddr    (wr_cnt_q[AW-1:0]),
    .wdata    (i_smp_data),
    .raddr    (samp_d),
    .rdata    (rdata)
  );

  always_comb begin
    smp12 = '0;
    for (int c = 0; c < NCH; c++)
      if (ch_q == 4'(c)) smp12[ADC_W-1:0] = rdata[c*ADC_W +: ADC_W];
  end

  assign eff_c = (AW+1)'(clamp_len(cap_len_q, LEN_W'(DEPTH)));

  always_comb begin
    state_d   = state_q;
    oe_n_d    = oe_n_q;
    rd_n_d    = rd_n_q;
    wr_n_d    = 1'b1;
    data_d    = data_q;
    cmd_d     = cmd_q;
    cap_len_d = cap_len_q;
    decim_d   = decim_q;
    dcnt_d    = dcnt_q;
    wr_cnt_d  = wr_cnt_q;
    eff_len_d = eff_len_q;
    samp_d    = samp_q;
    ch_d      = ch_q;
    left_d    = left_q;
    hdr_d     = hdr_q;
    buf_we    = 1'b0;
    case (state_q)
      ST_IDLE: if (!i_ft_rxf_n) begin
        oe_n_d  = 1'b0;
        state_d = ST_RD_OE;
      end
      ST_RD_OE: if (!i_ft_rxf_n) begin
        rd_n_d  = 1'b0;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        oe_n_d  = 1'b1;
        rd_n_d  = 1'b1;
        cmd_d   = io_ft_data;
        state_d = ST_IDLE;
        case (io_ft_data[15:12])
          OP_LEN_LO:  cap_len_d[11:0]       = io_ft_data[11:0];
          OP_LEN_HI:  cap_len_d[LEN_W-1:12] = io_ft_data;
          OP_DECIM:   decim_d               = io_ft_data[7:0];
          OP_LOOP:    state_d               = ST_LOOPBACK;
          OP_CAPTURE: begin
            state_d   = ST_CAPTURE;
            eff_len_d = eff_c;
            dcnt_d    = '0;
            wr_cnt_d  = '0;
            samp_d    = '0;
            ch_d      = '0;
            hdr_d     = 1'b0;
            left_d    = WLW'(eff_c) * WLW'(NCH);
          end
          default: ;
        endcase
      end
      ST_CAPTURE: if (i_smp_valid) begin
        dcnt_d = (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
        if (dcnt_q == 8'd0) begin
          buf_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + (AW+1)'(1);
          if (wr_cnt_d == eff_len_q)
`ifdef FRAME_HEADER_EN
            state_d = ST_HEADER;
`else
            state_d = ST_STREAM;
`endif
        end
      end
`ifdef FRAME_HEADER_EN
      ST_HEADER: if (!i_ft_txe_n) begin
        wr_n_d = 1'b0;
        data_d = hdr_q ? {decim_q, 4'(NCH-1), 4'h0} : FRAME_HDR;
        hdr_d  = 1'b1;
        if (hdr_q) state_d = ST_STREAM;
      end
`endif
      ST_STREAM: if (!i_ft_txe_n) begin
        wr_n_d = 1'b0;
        data_d = {ch_q, smp12};
        left_d = left_q - WLW'(1);
        if (ch_q == 4'(NCH-1)) begin
          ch_d   = '0;
          samp_d = samp_q + AW'(1);
        end else begin
          ch_d   = ch_q + 4'd1;
        end
        if (left_q == WLW'(1)) state_d = ST_IDLE;
      end
      ST_LOOPBACK: if (!i_ft_txe_n) begin
        wr_n_d  = 1'b0;
        data_d  = cmd_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_ft_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      oe_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      data_q    <= '0;
      cmd_q     <= '0;
      cap_len_q <= LEN_W'(DEPTH);
      decim_q   <= '0;
      dcnt_q    <= '0;
      wr_cnt_q  <= '0;
      eff_len_q <= '0;
      samp_q    <= '0;
      ch_q      <= '0;
      left_q    <= '0;
      hdr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      oe_n_q    <= oe_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      data_q    <= data_d;
      cmd_q     <= cmd_d;
      cap_len_q <= cap_len_d;
      decim_q   <= decim_d;
      dcnt_q    <= dcnt_d;
      wr_cnt_q  <= wr_cnt_d;
      eff_len_q <= eff_len_d;
      samp_q    <= samp_d;
      ch_q      <= ch_d;
      left_q    <= left_d;
      hdr_q     <= hdr_d;
    end
  end

endmodule

// File: tb/tb_ft600_mch_capture.sv
// Scoreboard bench: stimulus pushes expected host words, a monitor pops on each write strobe.
module tb_ft600_mch_capture;

  localparam int NCH   = 2;
  localparam int ADC_W = 10;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxf_n = 1'b1;
  logic        txe_n = 1'b1;
  logic        valid = 1'b0;
  logic [19:0] smp = '0;
  logic [15:0] host_cmd = '0;
  logic        oe_n, rd_n, wr_n, busy;
  logic [2:0]  st;
  wire  [15:0] ft_data;
  wire  [1:0]  ft_be;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  bit          txe_rand  = 1'b0;
  logic        txe_fixed = 1'b0;

  assign ft_data = oe_n ? 16'hzzzz : host_cmd;
  assign ft_be   = oe_n ? 2'bzz : 2'b11;

  ft600_mch_capture #(.NCH(NCH), .ADC_W(ADC_W), .DEPTH(DEPTH)) dut (
    .i_ft_clk    (clk),
    .rst         (rst),
    .i_ft_rxf_n  (rxf_n),
    .i_ft_txe_n  (txe_n),
    .o_ft_oe_n   (oe_n),
    .o_ft_rd_n   (rd_n),
    .o_ft_wr_n   (wr_n),
    .io_ft_be    (ft_be),
    .io_ft_data  (ft_data),
    .i_smp_valid (valid),
    .i_smp_data  (smp),
    .o_busy      (busy),
    .o_state     (st)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) txe_n = txe_rand ? 1'($urandom_range(0, 1)) : txe_fixed;

  always @(negedge clk) begin
    if (!rst && wr_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected word: got %h expected none", ft_data);
      end else begin
        check("stream word", {16'h0, ft_data}, {16'h0, exp_q.pop_front()});
      end
      check("be during write", {30'h0, ft_be}, 32'h3);
    end
  end

  task automatic push_frame(input int decim, input int len);
`ifdef FRAME_HEADER_EN
    exp_q.push_back(16'hA55A);
    exp_q.push_back({8'(decim), 4'(NCH-1), 4'h0});
`endif
    for (int k = 0; k < len; k++) begin
      int n = k * (decim + 1);
      exp_q.push_back({4'h0, 12'(n)});
      exp_q.push_back({4'h1, 12'(n + 'h200)});
    end
  endtask

  task automatic send_cmd(input logic [15:0] cmd);
    bit done = 1'b0;
    @(negedge clk);
    host_cmd = cmd;
    rxf_n    = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (rd_n === 1'b0) begin
        rxf_n = 1'b1;
        done  = 1'b1;
      end
    end
    rxf_n = 1'b1;
    check("read handshake", {31'h0, done}, 32'h1);
  endtask

  task automatic wait_idle(input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (st == 3'd0) done = 1'b1;
    end
    check("return to idle", {31'h0, done}, 32'h1);
    repeat (2) @(negedge clk);
    check("queue drained", exp_q.size(), 0);
  endtask

  // Ramp samples at every cycle while the DUT sits in CAPTURE.
  task automatic run_capture();
    int n = 0;
    send_cmd(16'hA000);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (st == 3'd3) begin
        if (n == 0) check("busy in capture", {31'h0, busy}, 32'h1);
        valid = 1'b1;
        smp   = {10'(n + 'h200), 10'(n)};
        n++;
      end else if (n > 0) break;
    end
    valid = 1'b0;
    check("capture entered", {31'h0, (n > 0)}, 32'h1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset oe_n", {31'h0, oe_n}, 32'h1);
    check("reset rd_n", {31'h0, rd_n}, 32'h1);
    check("reset wr_n", {31'h0, wr_n}, 32'h1);
    check("reset state", {29'h0, st}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset data bus", {16'h0, ft_data}, 32'h0);
    check("reset be bus", {30'h0, ft_be}, 32'h0);
    rst = 1'b0;

    exp_q.push_back(16'h7123);
    send_cmd(16'h7123);
    wait_idle(50);

    send_cmd(16'h1004);
    push_frame(0, 4);
    run_capture();
    wait_idle(200);

    send_cmd(16'h3002);
    send_cmd(16'h1003);
    push_frame(2, 3);
    run_capture();
    wait_idle(200);

    send_cmd(16'h3000);
    send_cmd(16'h1040);
    txe_rand = 1'b1;
    push_frame(0, 64);
    run_capture();
    wait_idle(2000);
    txe_rand = 1'b0;

    send_cmd(16'h1000);
    push_frame(0, DEPTH);
    run_capture();
    wait_idle(1000);

    send_cmd(16'h1005);
    send_cmd(16'h2001);
    push_frame(0, DEPTH);
    run_capture();
    wait_idle(1000);

    send_cmd(16'h5ABC);
    repeat (3) @(negedge clk);
    check("unlisted opcode idle", {29'h0, st}, 32'h0);
    check("unlisted opcode busy", {31'h0, busy}, 32'h0);

    send_cmd(16'h1020);
    push_frame(0, 32);
    run_capture();
    repeat (20) @(negedge clk);
    check("mid-stream state", {29'h0, st}, 32'h5);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort wr_n", {31'h0, wr_n}, 32'h1);
    check("abort oe_n", {31'h0, oe_n}, 32'h1);
    check("abort state", {29'h0, st}, 32'h0);
    check("abort busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    push_frame(0, DEPTH);
    run_capture();
    wait_idle(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
